keypad_digit_buffer: RTL

- Parametrised multi-slot digit-entry buffer for keypad input.
- Captures a DIGIT_W-bit key code into the slot under a cursor on each key press, and moves the cursor on advance/backspace commands.
- Tracks which slots hold valid data and reports EMPTY/PARTIAL/FULL status.
- Sits between the keypad scanner and the 7-segment display mux; the packed digit bus drives the display directly.

---
 rtl/keypad_pkg.sv | 14 +
 rtl/keypad_cursor_ctr.sv | 55 +++++
 rtl/keypad_digit_buffer.sv | 114 +++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad digit-entry buffer: status encodings and
// default geometry.
package keypad_pkg;

    // Buffer fill status reported on the state output
    localparam logic [1:0] ST_EMPTY   = 2'd0;
    localparam logic [1:0] ST_PARTIAL = 2'd1;
    localparam logic [1:0] ST_FULL    = 2'd2;

    // Default geometry: four hex/BCD digits
    localparam int unsigned DEFAULT_DIGIT_W    = 4;
    localparam int unsigned DEFAULT_NUM_DIGITS = 4;

endpackage

// File: rtl/keypad_cursor_ctr.sv
// Up/down cursor counter for the digit buffer. Priority is clear > down > up.
// WRAP=1 wraps at both ends, WRAP=0 saturates at 0 and NUM_DIGITS-1.
// cursor_next_o exposes the next-state value so the parent can address the
// slot the cursor is about to land on (used by backspace erase).
module keypad_cursor_ctr #(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned WRAP       = 1
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          clr_i,
    input  logic                          dec_i,
    input  logic                          inc_i,
    output logic [$clog2(NUM_DIGITS)-1:0] cursor_o,
    output logic [$clog2(NUM_DIGITS)-1:0] cursor_next_o
);

    localparam int unsigned CW = $clog2(NUM_DIGITS);
    localparam logic [CW-1:0] MaxIdx = CW'(NUM_DIGITS - 1);

    logic [CW-1:0] cursor_q, cursor_d;

    // Next cursor position from the highest-priority active command
    always_comb begin
        cursor_d = cursor_q;
        if (clr_i) begin
            cursor_d = '0;
        end else if (dec_i) begin
            if (cursor_q != '0) begin
                cursor_d = cursor_q - 1'b1;
            end else if (WRAP != 0) begin
                cursor_d = MaxIdx;
            end
        end else if (inc_i) begin
            if (cursor_q != MaxIdx) begin
                cursor_d = cursor_q + 1'b1;
            end else if (WRAP != 0) begin
                cursor_d = '0;
            end
        end
    end

    // Cursor register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cursor_q <= '0;
        end else begin
            cursor_q <= cursor_d;
        end
    end

    assign cursor_o      = cursor_q;
    assign cursor_next_o = cursor_d;

endmodule

// File: rtl/keypad_digit_buffer.sv
// Multi-slot keypad digit-entry buffer. Key presses land in the slot under the
// cursor; advance/backspace move it; clear wipes everything. A valid mask
// tracks written slots and drives EMPTY/PARTIAL/FULL status, with a one-cycle
// entry_done pulse on reaching FULL.
// Build option: define KEYPAD_AUTO_ADV_EN to make each key press also advance
// the cursor (press+advance together still moves one step).
module keypad_digit_buffer
    import keypad_pkg::*;
#(
    parameter int unsigned DIGIT_W    = DEFAULT_DIGIT_W,
    parameter int unsigned NUM_DIGITS = DEFAULT_NUM_DIGITS,
    parameter int unsigned WRAP       = 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [DIGIT_W-1:0]              key,
    input  logic                            pressed,
    input  logic                            advance,
    input  logic                            backspace,
    input  logic                            clear,
    output logic [NUM_DIGITS*DIGIT_W-1:0]   digits,
    output logic [NUM_DIGITS-1:0]           valid_mask,
    output logic [$clog2(NUM_DIGITS)-1:0]   cursor,
    output logic [1:0]                      state,
    output logic                            entry_done
);

    localparam int unsigned CW = $clog2(NUM_DIGITS);

    logic [DIGIT_W-1:0]    slot_q [NUM_DIGITS];
    logic [DIGIT_W-1:0]    slot_d [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] mask_q, mask_d;
    logic [1:0]            state_q, state_d;
    logic                  done_q, done_d;
    logic [CW-1:0]         cursor_q, cursor_next;
    logic                  step_fwd;

`ifdef KEYPAD_AUTO_ADV_EN
    assign step_fwd = advance | pressed;
`else
    assign step_fwd = advance;
`endif

    keypad_cursor_ctr #(
        .NUM_DIGITS (NUM_DIGITS),
        .WRAP       (WRAP)
    ) u_cursor (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .clr_i         (clear),
        .dec_i         (backspace),
        .inc_i         (step_fwd),
        .cursor_o      (cursor_q),
        .cursor_next_o (cursor_next)
    );

    // Slot and mask update; backspace erases the slot the cursor moves onto,
    // a key press writes the slot under the pre-move cursor.
    always_comb begin
        slot_d = slot_q;
        mask_d = mask_q;
        if (clear) begin
            for (int i = 0; i < int'(NUM_DIGITS); i++) begin
                slot_d[i] = '0;
            end
            mask_d = '0;
        end else if (backspace) begin
            slot_d[cursor_next] = '0;
            mask_d[cursor_next] = 1'b0;
        end else if (pressed) begin
            slot_d[cursor_q] = key;
            mask_d[cursor_q] = 1'b1;
        end
    end

    // Status follows the next mask; entry_done fires only on the edge into FULL
    always_comb begin
        if (mask_d == '0) begin
            state_d = ST_EMPTY;
        end else if (&mask_d) begin
            state_d = ST_FULL;
        end else begin
            state_d = ST_PARTIAL;
        end
        done_d = (state_d == ST_FULL) && (state_q != ST_FULL);
    end

    // Storage, mask and status registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NUM_DIGITS); i++) begin
                slot_q[i] <= '0;
            end
            mask_q  <= '0;
            state_q <= ST_EMPTY;
            done_q  <= 1'b0;
        end else begin
            slot_q  <= slot_d;
            mask_q  <= mask_d;
            state_q <= state_d;
            done_q  <= done_d;
        end
    end

    for (genvar i = 0; i < int'(NUM_DIGITS); i++) begin : g_pack
        assign digits[i*DIGIT_W +: DIGIT_W] = slot_q[i];
    end

    assign valid_mask = mask_q;
    assign cursor     = cursor_q;
    assign state      = state_q;
    assign entry_done = done_q;

endmodule
